dispatch_steer: RTL and testbench

- Producer side of the Rename→Issue push interface.
- Accepts one renamed instruction per cycle from Rename into a small in-order dispatch buffer.
- Classifies each entry as memory (MemRead or MemWrite set) or non-memory.
- Pushes the oldest entry into the LSQ or IQ using the issue stage's pushReq/pushData/full handshake, preserving program order across both queues.

---
 rtl/dispatch_steer.sv | 81 ++++++++
 tb/tb_dispatch_steer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dispatch_steer.sv
// dispatch_steer: in-order dispatch buffer steering renamed instructions into the IQ or LSQ.
module dispatch_steer #(
  parameter int RENISS_WIDTH = 151,
  parameter int DB_ADDR_BITS = 2,
  parameter int MEMWRITE_BIT = 40,
  parameter int MEMREAD_BIT  = 39,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    FREEZE,
  input  logic                    FLUSH_IN,
  input  logic                    REN_valid_IN,
  input  logic [RENISS_WIDTH-1:0] REN_data_IN,
  output logic                    REN_stall_OUT,
  output logic                    IQ_pushReq_OUT,
  output logic [RENISS_WIDTH-1:0] IQ_pushData_OUT,
  input  logic                    IQ_full_IN,
  output logic                    LSQ_pushReq_OUT,
  output logic [RENISS_WIDTH-1:0] LSQ_pushData_OUT,
  input  logic                    LSQ_full_IN,
  output logic [CNT_WIDTH-1:0]    IQ_disp_count_OUT,
  output logic [CNT_WIDTH-1:0]    LSQ_disp_count_OUT,
  output logic [CNT_WIDTH-1:0]    blocked_cycles_OUT
);
  localparam int DEPTH = 1 << DB_ADDR_BITS;
  localparam int CW = DB_ADDR_BITS + 1;

  logic [RENISS_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]        mem_q;
  logic [DB_ADDR_BITS-1:0] head, tail;
  logic [CW-1:0]           count;
  logic                    disp_ok, head_mem, accept, pop, blocked;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
    return (en && !(&c)) ? c + CNT_WIDTH'(1) : c;
  endfunction

  always_comb begin
    REN_stall_OUT    = !RESET & ((count == CW'(DEPTH)) | FREEZE);
    disp_ok          = !RESET & (count != '0) & !FREEZE & !FLUSH_IN;
    head_mem         = mem_q[head];
    LSQ_pushReq_OUT  = disp_ok & head_mem & !LSQ_full_IN;
    IQ_pushReq_OUT   = disp_ok & !head_mem & !IQ_full_IN;
    LSQ_pushData_OUT = LSQ_pushReq_OUT ? data_q[head] : '0;
    IQ_pushData_OUT  = IQ_pushReq_OUT ? data_q[head] : '0;
    blocked          = disp_ok & (head_mem ? LSQ_full_IN : IQ_full_IN);
    accept           = !RESET & REN_valid_IN & !REN_stall_OUT & !FLUSH_IN;
    pop              = LSQ_pushReq_OUT | IQ_pushReq_OUT;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      IQ_disp_count_OUT  <= '0;
      LSQ_disp_count_OUT <= '0;
      blocked_cycles_OUT <= '0;
    end else if (FLUSH_IN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + DB_ADDR_BITS'(1);
      if (pop) head <= head + DB_ADDR_BITS'(1);
      count              <= count + CW'(accept) - CW'(pop);
      IQ_disp_count_OUT  <= sat_inc(IQ_disp_count_OUT, IQ_pushReq_OUT);
      LSQ_disp_count_OUT <= sat_inc(LSQ_disp_count_OUT, LSQ_pushReq_OUT);
      blocked_cycles_OUT <= sat_inc(blocked_cycles_OUT, blocked);
    end
  end

  // entry storage is never reset; validity is tracked by count alone
  always_ff @(posedge CLK) begin
    if (accept) begin
      data_q[tail] <= REN_data_IN;
      mem_q[tail]  <= REN_data_IN[MEMREAD_BIT] | REN_data_IN[MEMWRITE_BIT];
    end
  end
endmodule

// File: tb/tb_dispatch_steer.sv
// tb_dispatch_steer: directed stimulus with a push-order scoreboard checked by an independent monitor.
module tb_dispatch_steer;
  localparam int W = 151;
  typedef struct { logic mem; logic [W-1:0] d; } exp_t;

  logic         CLK = 0, RESET = 1, FREEZE = 0, FLUSH_IN = 0, REN_valid_IN = 0;
  logic [W-1:0] REN_data_IN = '0;
  logic         REN_stall_OUT, IQ_pushReq_OUT, LSQ_pushReq_OUT, IQ_full_IN = 0, LSQ_full_IN = 0;
  logic [W-1:0] IQ_pushData_OUT, LSQ_pushData_OUT;
  logic [15:0]  IQ_disp_count_OUT, LSQ_disp_count_OUT, blocked_cycles_OUT;
  exp_t         exp_q[$];
  int           checks = 0, failures = 0;

  dispatch_steer dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH_IN(FLUSH_IN),
    .REN_valid_IN(REN_valid_IN), .REN_data_IN(REN_data_IN), .REN_stall_OUT(REN_stall_OUT),
    .IQ_pushReq_OUT(IQ_pushReq_OUT), .IQ_pushData_OUT(IQ_pushData_OUT), .IQ_full_IN(IQ_full_IN),
    .LSQ_pushReq_OUT(LSQ_pushReq_OUT), .LSQ_pushData_OUT(LSQ_pushData_OUT), .LSQ_full_IN(LSQ_full_IN),
    .IQ_disp_count_OUT(IQ_disp_count_OUT), .LSQ_disp_count_OUT(LSQ_disp_count_OUT),
    .blocked_cycles_OUT(blocked_cycles_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int id, input bit ld, input bit st);
    logic [W-1:0] w;
    w = W'({5{id}});
    w[39] = ld;
    w[40] = st;
    return w;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] w, input bit acc);
    REN_valid_IN = v;
    REN_data_IN  = w;
    if (acc) exp_q.push_back('{w[39] | w[40], w});
  endtask

  // monitor: every push must match the oldest outstanding expected entry
  always @(negedge CLK) begin
    if (!RESET) begin
      if (!IQ_pushReq_OUT) chk("iq_data_idle", IQ_pushData_OUT, '0);
      if (!LSQ_pushReq_OUT) chk("lsq_data_idle", LSQ_pushData_OUT, '0);
      if (IQ_pushReq_OUT || LSQ_pushReq_OUT) begin
        chk("one_hot_push", W'(IQ_pushReq_OUT & LSQ_pushReq_OUT), '0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_push iq=%0h lsq=%0h", IQ_pushData_OUT, LSQ_pushData_OUT);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_target_lsq", W'(LSQ_pushReq_OUT), W'(e.mem));
          chk("sb_data", LSQ_pushReq_OUT ? LSQ_pushData_OUT : IQ_pushData_OUT, e.d);
        end
      end
    end
  end

  initial begin
    cyc(); cyc();
    @(negedge CLK);
    chk("rst_stall", W'(REN_stall_OUT), 0);
    chk("rst_iq_req", W'(IQ_pushReq_OUT), 0);
    chk("rst_lsq_req", W'(LSQ_pushReq_OUT), 0);
    chk("rst_iq_cnt", W'(IQ_disp_count_OUT), 0);
    chk("rst_blk_cnt", W'(blocked_cycles_OUT), 0);
    cyc(); RESET = 0;
    // single ALU op
    cyc(); drive(1, mk(1, 0, 0), 1);
    @(negedge CLK); chk("t1_no_bypass", W'(IQ_pushReq_OUT), 0);
    cyc(); drive(0, '0, 0);
    @(negedge CLK); chk("t1_iq_push", W'(IQ_pushReq_OUT), 1);
    cyc();
    @(negedge CLK);
    chk("t1_iq_cnt", W'(IQ_disp_count_OUT), 1);
    chk("t1_lsq_cnt", W'(LSQ_disp_count_OUT), 0);
    // load, ALU, store, ALU streamed back to back
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1, mk(10 + i, i == 0, i == 2), 1);
      @(negedge CLK);
      chk("stream_stall", W'(REN_stall_OUT), 0);
      chk("stream_lsq_req", W'(LSQ_pushReq_OUT), W'(i % 2 == 1));
    end
    cyc(); drive(0, '0, 0);
    @(negedge CLK); chk("stream_last_iq", W'(IQ_pushReq_OUT), 1);
    cyc(); cyc();
    @(negedge CLK);
    chk("stream_iq_cnt", W'(IQ_disp_count_OUT), 3);
    chk("stream_lsq_cnt", W'(LSQ_disp_count_OUT), 2);
    // load stuck on a full LSQ holds back younger ALU ops
    cyc(); LSQ_full_IN = 1; drive(1, mk(20, 1, 0), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1, mk(21 + i, 0, 0), i < 3);
      @(negedge CLK);
      chk("blk_no_iq", W'(IQ_pushReq_OUT), 0);
      chk("blk_stall", W'(REN_stall_OUT), W'(i == 3));
    end
    cyc(); drive(0, '0, 0);
    @(negedge CLK); chk("blk_cycles_4", W'(blocked_cycles_OUT), 4);
    cyc(); LSQ_full_IN = 0;
    @(negedge CLK);
    chk("blk_cycles_5", W'(blocked_cycles_OUT), 5);
    chk("blk_release_lsq", W'(LSQ_pushReq_OUT), 1);
    repeat (4) cyc();
    @(negedge CLK);
    chk("blk_iq_cnt", W'(IQ_disp_count_OUT), 6);
    chk("blk_lsq_cnt", W'(LSQ_disp_count_OUT), 3);
    // full buffer: no pass-through, then accept+dispatch together
    IQ_full_IN = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1, mk(30 + i, 0, 0), 1);
    end
    cyc(); IQ_full_IN = 0; drive(1, mk(99, 0, 0), 0);
    @(negedge CLK);
    chk("full_stall", W'(REN_stall_OUT), 1);
    chk("full_iq_req", W'(IQ_pushReq_OUT), 1);
    cyc(); drive(1, mk(34, 0, 0), 1);
    @(negedge CLK);
    chk("full_after_stall", W'(REN_stall_OUT), 0);
    chk("full_after_iq_req", W'(IQ_pushReq_OUT), 1);
    cyc(); drive(0, '0, 0);
    repeat (3) cyc();
    @(negedge CLK);
    chk("full_iq_cnt", W'(IQ_disp_count_OUT), 11);
    chk("full_blk_cnt", W'(blocked_cycles_OUT), 8);
    // freeze with two entries buffered
    IQ_full_IN = 1; LSQ_full_IN = 1;
    cyc(); drive(1, mk(40, 0, 0), 1);
    cyc(); drive(1, mk(41, 1, 0), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); FREEZE = 1; drive(1, mk(98, 0, 0), 0);
      @(negedge CLK);
      chk("frz_stall", W'(REN_stall_OUT), 1);
      chk("frz_iq_req", W'(IQ_pushReq_OUT), 0);
      chk("frz_lsq_req", W'(LSQ_pushReq_OUT), 0);
    end
    chk("frz_blk_hold", W'(blocked_cycles_OUT), 9);
    chk("frz_iq_hold", W'(IQ_disp_count_OUT), 11);
    cyc(); FREEZE = 0; IQ_full_IN = 0; LSQ_full_IN = 0; drive(0, '0, 0);
    @(negedge CLK); chk("frz_rel_iq", W'(IQ_pushReq_OUT), 1);
    cyc();
    @(negedge CLK); chk("frz_rel_lsq", W'(LSQ_pushReq_OUT), 1);
    cyc();
    @(negedge CLK);
    chk("frz_iq_cnt", W'(IQ_disp_count_OUT), 12);
    chk("frz_lsq_cnt", W'(LSQ_disp_count_OUT), 4);
    // flush with three entries buffered
    IQ_full_IN = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); drive(1, mk(50 + i, 0, 0), 1);
    end
    cyc(); FLUSH_IN = 1; IQ_full_IN = 0; drive(1, mk(53, 0, 0), 0);
    exp_q.delete();
    @(negedge CLK); chk("flush_no_push", W'(IQ_pushReq_OUT), 0);
    cyc(); FLUSH_IN = 0; drive(0, '0, 0);
    @(negedge CLK); chk("flush_empty", W'(IQ_pushReq_OUT), 0);
    cyc();
    @(negedge CLK);
    chk("flush_iq_cnt_kept", W'(IQ_disp_count_OUT), 12);
    chk("flush_blk_cnt_kept", W'(blocked_cycles_OUT), 11);
    cyc(); RESET = 1;
    cyc(); RESET = 0;
    @(negedge CLK);
    chk("rst2_iq_cnt", W'(IQ_disp_count_OUT), 0);
    chk("rst2_lsq_cnt", W'(LSQ_disp_count_OUT), 0);
    chk("rst2_blk_cnt", W'(blocked_cycles_OUT), 0);
    chk("sb_drained", W'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
